// File: rtl/sample_capture.sv
// sample_capture
//   Write-side controller for the scope sample RAM. After an arm pulse it
//   streams valid ADC samples into the RAM as a circular buffer, watches for a
//   level crossing, and stops once DEPTH - P samples (including the trigger
//   sample) have been written after the trigger. P is the pre-trigger count.
//   The trigger-sample address is published on trig_addr. The reader finds the
//   oldest sample at trig_addr - P (mod DEPTH).
//
//   Optional feature (macro CAPTURE_AUTO_TRIG_EN): a trigger is forced after
//   AUTO_TIMEOUT non-triggering samples in WAIT_TRIG, and forced is then set.
//   When the macro is not defined, forced is tied to 0.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   arm, abort        single-cycle control pulses (abort wins over arm)
//   sample_valid      strobe qualifying sample_data
//   sample_data       unsigned ADC sample
//   trig_level        trigger threshold (latched at arm)
//   trig_rising       1 = rising, 0 = falling trigger (latched at arm)
//   pretrig           pre-trigger sample count P (latched at arm)
//   mem_addr/data     registered RAM write address / data
//   mem_cs/mem_we     registered RAM chip select / write enable
//   busy, done        capture in progress / capture complete
//   trig_addr         address of the trigger sample
//   forced            last trigger was forced by timeout
module sample_capture #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_rising,
    input  logic [ADDR_WIDTH-1:0] pretrig,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  forced
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    if (AUTO_TIMEOUT < 1) begin : g_bad_timeout
        $error("sample_capture: AUTO_TIMEOUT must be at least 1");
    end

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] p_reg;
    logic [DATA_WIDTH-1:0] level_reg;
    logic                  rising_reg;
    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_valid;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   post_total;
    logic                  hit;
    logic                  force_hit;
    logic                  fire;

    // DEPTH - P, one bit wider than the address so P = 0 gives DEPTH.
    assign post_total = {1'b1, {ADDR_WIDTH{1'b0}}} - {1'b0, p_reg};

    assign busy = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign done = (state == S_DONE);

    // Level crossing against the previous accepted sample; never on the first
    // sample after arm.
    always_comb begin
        hit = 1'b0;
        if (prev_valid) begin
            if (rising_reg) begin
                hit = (prev < level_reg) && (sample_data >= level_reg);
            end else begin
                hit = (prev > level_reg) && (sample_data <= level_reg);
            end
        end
    end

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    assign force_hit = !hit && (tcnt == TW'(AUTO_TIMEOUT));

    // tcnt only moves in WAIT_TRIG and is cleared at arm, so every entry into
    // WAIT_TRIG starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt   <= '0;
            forced <= 1'b0;
        end else if (!abort) begin
            if ((state == S_IDLE || state == S_DONE) && arm) begin
                tcnt   <= '0;
                forced <= 1'b0;
            end else if (state == S_WAIT && sample_valid) begin
                if (fire) begin
                    forced <= force_hit;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end
`else
    assign force_hit = 1'b0;
    assign forced    = 1'b0;
`endif

    assign fire = hit || force_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            p_reg      <= '0;
            level_reg  <= '0;
            rising_reg <= 1'b0;
            prev       <= '0;
            prev_valid <= 1'b0;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            trig_addr  <= '0;
        end else begin
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            level_reg  <= trig_level;
                            rising_reg <= trig_rising;
                            p_reg      <= pretrig;
                            cnt        <= '0;
                            prev_valid <= 1'b0;
                            state      <= (pretrig != '0) ? S_PRE : S_WAIT;
                        end
                    end
                    S_PRE, S_WAIT, S_POST: begin
                        if (sample_valid) begin
                            mem_cs     <= 1'b1;
                            mem_we     <= 1'b1;
                            mem_addr   <= wr_ptr;
                            mem_data   <= sample_data;
                            wr_ptr     <= wr_ptr + 1'b1;
                            prev       <= sample_data;
                            prev_valid <= 1'b1;
                            case (state)
                                S_PRE: begin
                                    if (cnt + 1'b1 == {1'b0, p_reg}) begin
                                        cnt   <= '0;
                                        state <= S_WAIT;
                                    end else begin
                                        cnt <= cnt + 1'b1;
                                    end
                                end
                                S_WAIT: begin
                                    if (fire) begin
                                        trig_addr <= wr_ptr;
                                        cnt       <= {{ADDR_WIDTH{1'b0}}, 1'b1};
                                        state     <= (post_total > {{ADDR_WIDTH{1'b0}}, 1'b1})
                                                     ? S_POST : S_DONE;
                                    end
                                end
                                default: begin
                                    if (cnt + 1'b1 == post_total) begin
                                        state <= S_DONE;
                                    end
                                    cnt <= cnt + 1'b1;
                                end
                            endcase
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
